// File: rtl/marker_pkg.sv
// Shared phase-marker encoding: phase ids, opcode fields and the marker word builder.
// The commit-side event monitor decodes words produced by encode_marker().
package marker_pkg;

    typedef enum logic [2:0] {
        PH_VCTM  = 3'd0,
        PH_DELAY = 3'd1,
        PH_TEXE  = 3'd2,
        PH_LEAK  = 3'd3,
        PH_INIT  = 3'd4,
        PH_BIM   = 3'd5,
        PH_TRAIN = 3'd6
    } phase_e;

    localparam logic [6:0] MARKER_OPC    = 7'h13;
    localparam logic [2:0] MARKER_F3     = 3'b010;
    localparam logic [2:0] PHASE_ILLEGAL = 3'd7;

    // slti x0, x0, {phase, is_end}: architecturally a no-op, visible at commit
    function automatic logic [31:0] encode_marker(input logic [2:0] phase, input logic is_end);
        logic [11:0] imm;
        imm = {8'd0, phase, is_end};
        return {imm, 5'd0, MARKER_F3, 5'd0, MARKER_OPC};
    endfunction

endpackage

// File: rtl/phase_marker_encoder_if.sv
// Request, upstream-instruction and frontend handshakes of the phase-marker encoder.
interface phase_marker_encoder_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_phase;
    logic        req_end;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_is_marker;

    modport master (
        output req_valid, req_phase, req_end, in_valid, in_inst, out_ready,
        input  req_ready, in_ready, out_valid, out_inst, out_is_marker
    );

    modport slave (
        input  req_valid, req_phase, req_end, in_valid, in_inst, out_ready,
        output req_ready, in_ready, out_valid, out_inst, out_is_marker
    );

endinterface

// File: rtl/marker_fifo.sv
// Synchronous FIFO of 4-bit marker codes with an occupancy count; FIFO_DEPTH must be a power of two.
module marker_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic [3:0]                  din,
    input  logic                        pop,
    output logic [3:0]                  dout,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/phase_marker_encoder.sv
// Splices queued phase-marker words into the upstream instruction stream, stalling the source meanwhile.
// Optional build macro MARKER_PAIR_CHECK_EN adds START/END pairing tracking (open_mask, err_unpaired).
module phase_marker_encoder
    import marker_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    phase_marker_encoder_if.slave bus,
    output logic [CNT_W-1:0]      marker_cnt,
    output logic                  err_illegal
`ifdef MARKER_PAIR_CHECK_EN
    ,
    output logic [6:0]            open_mask,
    output logic                  err_unpaired
`endif
);

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    logic [CW-1:0] fifo_count;
    logic [3:0]    head_code;
    logic [3:0]    req_code;
    logic          fifo_empty;
    logic          load_en;
    logic          req_fire;
    logic          req_illegal;
    logic          push;
    logic          pop;
    logic          deliver_marker;

    logic          vld_p1;
    logic [31:0]   inst_p1;
    logic          is_marker_p1;

    assign req_code       = {bus.req_phase, bus.req_end};
    assign fifo_empty     = (fifo_count == '0);
    assign load_en        = !vld_p1 || bus.out_ready;
    assign bus.req_ready  = (fifo_count < DEPTH_C);
    assign req_fire       = bus.req_valid && bus.req_ready;
    assign req_illegal    = (bus.req_phase == PHASE_ILLEGAL);
    assign push           = req_fire && !req_illegal;
    assign pop            = load_en && !fifo_empty;
    // a request pushed this cycle is not yet visible in the count, so it never blocks upstream
    assign bus.in_ready   = load_en && fifo_empty;
    assign deliver_marker = vld_p1 && bus.out_ready && is_marker_p1;

    marker_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (req_code),
        .pop   (pop),
        .dout  (head_code),
        .count (fifo_count)
    );

    // ---- p1: output holding register, markers take priority over upstream words
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1       <= 1'b0;
            inst_p1      <= '0;
            is_marker_p1 <= 1'b0;
        end else if (load_en) begin
            if (!fifo_empty) begin
                vld_p1       <= 1'b1;
                inst_p1      <= encode_marker(head_code[3:1], head_code[0]);
                is_marker_p1 <= 1'b1;
            end else if (bus.in_valid) begin
                vld_p1       <= 1'b1;
                inst_p1      <= bus.in_inst;
                is_marker_p1 <= 1'b0;
            end else begin
                vld_p1       <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = vld_p1;
    assign bus.out_inst      = inst_p1;
    assign bus.out_is_marker = is_marker_p1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            marker_cnt  <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (deliver_marker)          marker_cnt  <= marker_cnt + 1'b1;
            if (req_fire && req_illegal) err_illegal <= 1'b1;
        end
    end

`ifdef MARKER_PAIR_CHECK_EN
    logic [2:0] dlv_phase;
    logic       dlv_end;
    logic [6:0] dlv_bit;
    logic       dlv_open;

    // phase and END flag sit in the immediate field of the delivered marker
    assign dlv_phase = inst_p1[23:21];
    assign dlv_end   = inst_p1[20];
    assign dlv_bit   = 7'd1 << dlv_phase;
    assign dlv_open  = |(open_mask & dlv_bit);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            open_mask    <= '0;
            err_unpaired <= 1'b0;
        end else if (deliver_marker) begin
            if (dlv_end) begin
                if (!dlv_open) err_unpaired <= 1'b1;
                open_mask <= open_mask & ~dlv_bit;
            end else begin
                if (dlv_open) err_unpaired <= 1'b1;
                open_mask <= open_mask | dlv_bit;
            end
        end
    end
`endif

endmodule

// File: tb/tb_phase_marker_encoder.sv
// Directed bench for phase_marker_encoder with hand-computed marker words and counts.
// Build with MARKER_PAIR_CHECK_EN defined to also cover the pairing tracker.
module tb_phase_marker_encoder;

    logic        clock;
    logic        reset;
    logic [15:0] marker_cnt;
    logic        err_illegal;
`ifdef MARKER_PAIR_CHECK_EN
    logic [6:0]  open_mask;
    logic        err_unpaired;
`endif

    int vectors     = 0;
    int miscompares = 0;

    phase_marker_encoder_if bus();

    phase_marker_encoder #(
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .marker_cnt   (marker_cnt),
        .err_illegal  (err_illegal)
`ifdef MARKER_PAIR_CHECK_EN
        ,
        .open_mask    (open_mask),
        .err_unpaired (err_unpaired)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int sent;
        int wrd;
        int mrk;
        logic [2:0]  ph4  [5];
        logic        en4  [5];
        logic [31:0] exp4 [5];

        ph4  = '{3'd1, 3'd1, 3'd3, 3'd4, 3'd5};
        en4  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp4 = '{32'h00302013, 32'h00702013, 32'h00802013, 32'h00a02013, 32'h00102013};

        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_phase = 3'd0;
        bus.req_end   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'h0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_inst", bus.out_inst, 32'h0);
        chk("rst_is_marker", bus.out_is_marker, 1'b0);
        chk("rst_marker_cnt", marker_cnt, 16'd0);
        chk("rst_err_illegal", err_illegal, 1'b0);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        reset = 1'b1;
        tick();

        // two markers into an idle stream, upstream word waits behind them
        bus.req_valid = 1'b1; bus.req_phase = 3'd0; bus.req_end = 1'b0;
        #1;
        chk("t1_req_ready", bus.req_ready, 1'b1);
        chk("t1_in_ready_idle", bus.in_ready, 1'b1);
        tick();
        bus.req_phase = 3'd6; bus.req_end = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.in_valid  = 1'b1; bus.in_inst = 32'h12345013;
        #1;
        chk("t1_m0_inst", bus.out_inst, 32'h00002013);
        chk("t1_m0_is_marker", bus.out_is_marker, 1'b1);
        chk("t1_m0_in_ready", bus.in_ready, 1'b0);
        tick();
        chk("t1_m1_inst", bus.out_inst, 32'h00d02013);
        chk("t1_m1_is_marker", bus.out_is_marker, 1'b1);
        chk("t1_m1_cnt", marker_cnt, 16'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("t1_word_inst", bus.out_inst, 32'h12345013);
        chk("t1_word_is_marker", bus.out_is_marker, 1'b0);
        chk("t1_cnt", marker_cnt, 16'd2);
        tick();
        chk("t1_drained", bus.out_valid, 1'b0);

        // continuous upstream words with one request spliced in
        sent = 0; wrd = 0; mrk = 0;
        bus.in_inst = 32'h00000013;
        for (int c = 0; c < 300 && (sent < 100 || bus.out_valid); c++) begin
            bus.req_valid = (c == 50);
            bus.req_phase = 3'd3;
            bus.req_end   = 1'b0;
            bus.in_valid  = (sent < 100);
            #1;
            if (c == 50) chk("t2_in_ready_at_req", bus.in_ready, 1'b1);
            if (c == 51) begin
                chk("t2_word_first", bus.out_is_marker, 1'b0);
                chk("t2_stall", bus.in_ready, 1'b0);
            end
            if (c == 52) begin
                chk("t2_marker_next", bus.out_is_marker, 1'b1);
                chk("t2_marker_inst", bus.out_inst, 32'h00602013);
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                if (bus.out_is_marker) mrk++;
                else wrd++;
            end
            tick();
        end
        bus.req_valid = 1'b0;
        bus.in_valid  = 1'b0;
        chk("t2_sent", sent, 100);
        chk("t2_words_out", wrd, 100);
        chk("t2_markers_out", mrk, 1);
        chk("t2_cnt", marker_cnt, 16'd3);

        // backpressure: presented marker held stable
        bus.out_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_phase = 3'd2; bus.req_end = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.in_valid = 1'b1; bus.in_inst = 32'hAAAA0013;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_inst", bus.out_inst, 32'h00402013);
            chk("t3_hold_valid", bus.out_valid, 1'b1);
            chk("t3_hold_in_ready", bus.in_ready, 1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t3_word_inst", bus.out_inst, 32'hAAAA0013);
        chk("t3_word_is_marker", bus.out_is_marker, 1'b0);
        chk("t3_cnt_once", marker_cnt, 16'd4);
        tick();
        chk("t3_drained", bus.out_valid, 1'b0);

        // fill the queue under backpressure, then release in order
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1; bus.req_phase = ph4[i]; bus.req_end = en4[i];
            #1;
            chk("t4_req_ready_fill", bus.req_ready, 1'b1);
            tick();
        end
        bus.req_phase = 3'd0; bus.req_end = 1'b1;
        #1;
        chk("t4_full", bus.req_ready, 1'b0);
        chk("t4_head_inst", bus.out_inst, 32'h00202013);
        tick();
        chk("t4_still_full", bus.req_ready, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk("t4_no_bypass", bus.req_ready, 1'b0);
        tick();
        chk("t4_order0", bus.out_inst, exp4[0]);
        chk("t4_req_ready_again", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        for (int j = 1; j < 5; j++) begin
            chk("t4_order", bus.out_inst, exp4[j]);
            chk("t4_is_marker", bus.out_is_marker, 1'b1);
            tick();
        end
        chk("t4_drained", bus.out_valid, 1'b0);
        chk("t4_cnt", marker_cnt, 16'd10);

        // illegal phase
        bus.req_valid = 1'b1; bus.req_phase = 3'd7; bus.req_end = 1'b0;
        #1;
        chk("t5_req_ready", bus.req_ready, 1'b1);
        chk("t5_err_before", err_illegal, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        chk("t5_err_set", err_illegal, 1'b1);
        tick();
        tick();
        chk("t5_no_marker", bus.out_valid, 1'b0);
        chk("t5_cnt", marker_cnt, 16'd10);
        chk("t5_err_sticky", err_illegal, 1'b1);

        // reset with markers queued and one presented
        bus.out_ready = 1'b0;
        for (int i = 1; i < 5; i++) begin
            bus.req_valid = 1'b1; bus.req_phase = 3'(i); bus.req_end = 1'b0;
            tick();
        end
        bus.req_valid = 1'b0;
        #1;
        chk("t6_pre_valid", bus.out_valid, 1'b1);
        chk("t6_pre_req_ready", bus.req_ready, 1'b1);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", bus.out_valid, 1'b0);
        chk("t6_rst_inst", bus.out_inst, 32'h0);
        chk("t6_rst_is_marker", bus.out_is_marker, 1'b0);
        chk("t6_rst_cnt", marker_cnt, 16'd0);
        chk("t6_rst_err", err_illegal, 1'b0);
        chk("t6_rst_req_ready", bus.req_ready, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("t6_in_ready", bus.in_ready, 1'b1);
        tick();
        tick();
        tick();
        chk("t6_no_stale", bus.out_valid, 1'b0);
        chk("t6_cnt_after", marker_cnt, 16'd0);

        // END without START
`ifdef MARKER_PAIR_CHECK_EN
        chk("t7_unpaired_rst", err_unpaired, 1'b0);
        chk("t7_mask_rst", open_mask, 7'd0);
`endif
        bus.req_valid = 1'b1; bus.req_phase = 3'd2; bus.req_end = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("t7_end_inst", bus.out_inst, 32'h00502013);
        chk("t7_end_is_marker", bus.out_is_marker, 1'b1);
        tick();
        chk("t7_cnt", marker_cnt, 16'd1);
`ifdef MARKER_PAIR_CHECK_EN
        chk("t7_unpaired", err_unpaired, 1'b1);
        chk("t7_mask_closed", open_mask, 7'd0);
        bus.req_valid = 1'b1; bus.req_phase = 3'd2; bus.req_end = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("t7_mask_open", open_mask, 7'b0000100);
        chk("t7_unpaired_sticky", err_unpaired, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
